fifo_uart_tx: RTL

Drain stage directly downstream of fifo_mem. It pops bytes from the FIFO read port and serialises each one as an 8N1 UART frame (start bit, 8 data bits LSB first, stop bit) on a single tx line. It never issues a read while the FIFO reports empty, so fifo_underflow must never assert because of this block.

---
 rtl/fifo_uart_tx_pkg.sv | 16 +
 rtl/fifo_uart_tx_baud.sv | 32 +++
 rtl/fifo_uart_tx.sv | 124 ++++++++++++
 3 files changed

// File: rtl/fifo_uart_tx_pkg.sv
// Shared types and constants for the FIFO-draining 8N1 UART transmitter.
package fifo_uart_tx_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StFetch = 3'd1,
    StLoad  = 3'd2,
    StStart = 3'd3,
    StData  = 3'd4,
    StStop  = 3'd5
  } state_e;

  localparam int unsigned DefClksPerBit = 16;
  localparam int unsigned FrameBits     = 10;

endpackage

// File: rtl/fifo_uart_tx_baud.sv
// Bit-period counter: runs 0..CLKS_PER_BIT-1 and wraps; held at zero while cleared.
module fifo_uart_tx_baud #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  output logic o_bit_end,
  output logic o_bit_near_end
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] NearCnt = CntW'(CLKS_PER_BIT - 2);

  logic [CntW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear || (r_cnt == LastCnt)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CntW'(1);
    end
  end

  assign o_bit_end      = (r_cnt == LastCnt);
  // One cycle ahead of bit_end, so the owner can register a last-cycle pulse.
  assign o_bit_near_end = (r_cnt == NearCnt);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from fifo_mem and sends each as an 8N1 frame; all outputs are registers.
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = DefClksPerBit
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_enable,
  input  logic              i_fifo_empty,
  input  logic [DATA_W-1:0] i_fifo_data,
  output logic              o_fifo_rd,
  output logic              o_tx,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic [15:0]       o_byte_count
);

  localparam int unsigned IdxW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_W - 1);

  state_e            r_state;
  logic [DATA_W-1:0] r_shift;
  logic [IdxW-1:0]   r_bit_idx;
  logic              r_tx;
  logic              r_fifo_rd;
  logic              r_busy;
  logic              r_frame_done;
  logic [15:0]       r_byte_count;

  logic w_start_ok;
  logic w_baud_clr;
  logic w_bit_end;
  logic w_bit_near_end;

  assign w_start_ok = i_enable && !i_fifo_empty;
  assign w_baud_clr = (r_state == StIdle) || (r_state == StFetch) || (r_state == StLoad);

  fifo_uart_tx_baud #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_clear        (w_baud_clr),
    .o_bit_end      (w_bit_end),
    .o_bit_near_end (w_bit_near_end)
  );

  // tx is loaded with the level of the upcoming bit at each bit boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_shift      <= '0;
      r_bit_idx    <= '0;
      r_tx         <= 1'b1;
      r_fifo_rd    <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_byte_count <= '0;
    end else begin
      r_fifo_rd    <= 1'b0;
      r_frame_done <= (r_state == StStop) && w_bit_near_end;
      case (r_state)
        StIdle: begin
          if (w_start_ok) begin
            r_state   <= StFetch;
            r_fifo_rd <= 1'b1;
            r_busy    <= 1'b1;
          end
        end
        StFetch: r_state <= StLoad;
        StLoad: begin
          r_shift <= i_fifo_data;
          r_tx    <= 1'b0;
          r_state <= StStart;
        end
        StStart: begin
          if (w_bit_end) begin
            r_state   <= StData;
            r_bit_idx <= '0;
            r_tx      <= r_shift[0];
          end
        end
        StData: begin
          if (w_bit_end) begin
            r_shift <= r_shift >> 1;
            if (r_bit_idx == LastIdx) begin
              r_state <= StStop;
              r_tx    <= 1'b1;
            end else begin
              r_bit_idx <= r_bit_idx + IdxW'(1);
              r_tx      <= r_shift[1];
            end
          end
        end
        StStop: begin
          if (w_bit_end) begin
            r_byte_count <= r_byte_count + 16'd1;
            if (w_start_ok) begin
              r_state   <= StFetch;
              r_fifo_rd <= 1'b1;
            end else begin
              r_state <= StIdle;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= StIdle;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_fifo_rd    = r_fifo_rd;
  assign o_tx         = r_tx;
  assign o_busy       = r_busy;
  assign o_frame_done = r_frame_done;
  assign o_byte_count = r_byte_count;

endmodule
